// File: rtl/arb_pkg.sv
// Shared types and helpers for the N-way round-robin arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_STALL = 2'd1,
        ARB_LOCK  = 2'd2
    } arb_state_t;

    // Cyclic successor of idx in 0..n-1; n need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/round_robin_arbiter_n_if.sv
// Request/grant bundle between N requesters and the arbiter.
interface round_robin_arbiter_n_if #(
    parameter int N = 4
);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     requests;
    logic             ready;
    logic             lock;
    logic [N-1:0]     grants;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;

    // Requester side drives requests/ready/lock and observes the grant.
    modport master (
        output requests, ready, lock,
        input  grants, grant_valid, grant_idx
    );

    // Arbiter side.
    modport slave (
        input  requests, ready, lock,
        output grants, grant_valid, grant_idx
    );
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, cyclic.
module rr_priority_pick #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     requests_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);
    localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N);
    localparam logic [N-1:0]   ONE   = N'(1);

    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] ffs;
    logic [IDX_W:0]   sum;
    logic             found;

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        dbl   = {requests_i, requests_i};
        rot   = N'(dbl >> ptr_i);
        ffs   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                ffs   = IDX_W'(i);
                found = 1'b1;
            end
        end
        // Undo the rotation modulo N without a divider.
        sum = {1'b0, ffs} + {1'b0, ptr_i};
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
        valid_o  = found;
        idx_o    = found ? sum[IDX_W-1:0] : '0;
        onehot_o = found ? (ONE << idx_o) : '0;
    end

endmodule

// File: rtl/round_robin_arbiter_n.sv
// N-way round-robin arbiter with ready handshake, stall hold and burst locking.
module round_robin_arbiter_n
    import arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    round_robin_arbiter_n_if.slave  bus
);
    localparam logic [N-1:0] ONE = N'(1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;

    logic [N-1:0]     pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    logic             hold;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

    rr_priority_pick #(.N(N)) u_pick (
        .requests_i (bus.requests),
        .ptr_i      (ptr_q),
        .onehot_o   (pick_onehot),
        .idx_o      (pick_idx),
        .valid_o    (pick_valid)
    );

    // A stalled or locked owner keeps the grant only while it still requests.
    always_comb begin
        hold = (state_q != ARB_IDLE) && bus.requests[owner_q];
        if (hold) begin
            gnt       = ONE << owner_q;
            gnt_idx   = owner_q;
            gnt_valid = 1'b1;
        end else begin
            gnt       = pick_onehot;
            gnt_idx   = pick_idx;
            gnt_valid = pick_valid;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (!gnt_valid) begin
            state_d = ARB_IDLE;
        end else if (bus.ready) begin
            ptr_d = IDX_W'(wrap_inc(32'(gnt_idx), N));
            if (bus.lock) begin
                owner_d = gnt_idx;
                state_d = ARB_LOCK;
            end else begin
                state_d = ARB_IDLE;
            end
        end else if (state_q == ARB_LOCK && hold) begin
            state_d = ARB_LOCK;
        end else begin
            owner_d = gnt_idx;
            state_d = ARB_STALL;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    assign bus.grants      = rst ? '0 : gnt;
    assign bus.grant_valid = rst ? 1'b0 : gnt_valid;
    assign bus.grant_idx   = rst ? '0 : gnt_idx;

endmodule
